// File: rtl/adj_pair_add_pipe.sv
// Two-stage elastic adjacent-lane pair/quad adder with valid/ready handshakes.
// Define ADJ_PAIR_ADD_ACC_EN to accumulate results per slot across beats, emitting one result per in_last group.
module adj_pair_add_pipe #(
    parameter int LANE_W = 16,
    parameter int LANES  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LANES*LANE_W-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_signed,
    input  logic                    in_quad,
    input  logic                    in_last,
    output logic [LANES*LANE_W-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int SW = 2 * LANE_W;
    localparam int NS = LANES / 2;
    localparam int NQ = LANES / 4;
    localparam int DW = LANES * LANE_W;

    logic          r_s1_valid;
    logic [DW-1:0] r_s1_pair;
    logic          r_s1_quad;
    logic          r_s2_valid;
    logic [DW-1:0] r_s2_data;

    logic          w_s2_ready;
    logic          w_s1_adv;
    logic          w_in_fire;
    logic [DW-1:0] w_pair;
    logic [DW-1:0] w_sum;
    logic [DW-1:0] w_quad;
    logic [DW-1:0] w_slot;

`ifdef ADJ_PAIR_ADD_ACC_EN
    logic          r_s1_last;
    logic [DW-1:0] r_acc;
`else
    logic          w_unused_last;
    assign w_unused_last = in_last;
`endif

    function automatic logic [SW-1:0] f_ext(input logic [LANE_W-1:0] v, input logic s);
        return s ? {{LANE_W{v[LANE_W-1]}}, v} : {{LANE_W{1'b0}}, v};
    endfunction

    // A stage may load when it is empty or its content leaves this same cycle.
    assign w_s2_ready = !r_s2_valid || out_ready;
    assign w_s1_adv   = r_s1_valid && w_s2_ready;
    assign in_ready   = !r_s1_valid || w_s1_adv;
    assign w_in_fire  = in_valid && in_ready;

    always_comb begin
        w_pair = '0;
        for (int k = 0; k < NS; k++) begin
            w_pair[SW*k +: SW] = f_ext(in_data[LANE_W*(2*k)   +: LANE_W], in_signed)
                               + f_ext(in_data[LANE_W*(2*k+1) +: LANE_W], in_signed);
        end
    end

    always_comb begin
        w_sum = '0;
        for (int k = 0; k < NS; k++) begin
`ifdef ADJ_PAIR_ADD_ACC_EN
            w_sum[SW*k +: SW] = r_acc[SW*k +: SW] + r_s1_pair[SW*k +: SW];
`else
            w_sum[SW*k +: SW] = r_s1_pair[SW*k +: SW];
`endif
        end
    end

    // Quad reduction is linear, so applying it to accumulated pair sums is exact.
    always_comb begin
        w_quad = '0;
        for (int j = 0; j < NQ; j++) begin
            w_quad[SW*j +: SW] = w_sum[SW*(2*j) +: SW] + w_sum[SW*(2*j+1) +: SW];
        end
    end

    assign w_slot = r_s1_quad ? w_quad : w_sum;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_valid <= 1'b0;
            r_s1_pair  <= '0;
            r_s1_quad  <= 1'b0;
`ifdef ADJ_PAIR_ADD_ACC_EN
            r_s1_last  <= 1'b0;
`endif
        end else if (w_in_fire) begin
            r_s1_valid <= 1'b1;
            r_s1_pair  <= w_pair;
            r_s1_quad  <= in_quad;
`ifdef ADJ_PAIR_ADD_ACC_EN
            r_s1_last  <= in_last;
`endif
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
`ifdef ADJ_PAIR_ADD_ACC_EN
            r_acc      <= '0;
`endif
        end else if (w_s1_adv) begin
`ifdef ADJ_PAIR_ADD_ACC_EN
            if (r_s1_last) begin
                r_s2_valid <= 1'b1;
                r_s2_data  <= w_slot;
                r_acc      <= '0;
            end else begin
                r_s2_valid <= 1'b0;
                r_acc      <= w_sum;
            end
`else
            r_s2_valid <= 1'b1;
            r_s2_data  <= w_slot;
`endif
        end else if (out_ready) begin
            r_s2_valid <= 1'b0;
        end
    end

    assign out_valid = r_s2_valid;
    assign out_data  = r_s2_data;

endmodule

// File: tb/tb_adj_pair_add_pipe.sv
// Directed bench for adj_pair_add_pipe: vector table plus backpressure, reset and
// (when ADJ_PAIR_ADD_ACC_EN is defined) accumulation sequences.
module tb_adj_pair_add_pipe;

    localparam int DW = 128;

    typedef struct {
        logic [DW-1:0] data;
        logic          sgn;
        logic          quad;
        logic [DW-1:0] exp;
    } vec_t;

    logic          clk;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          in_signed;
    logic          in_quad;
    logic          in_last;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;

    vec_t vt[8];
    int   n_pass, n_tot;
    int   src_list[8];
    int   exp_list[8];
    int   src_n, src_pos, exp_n, out_pos;
    int   stall_cnt;
    bit   last_all;

    adj_pair_add_pipe #(.LANE_W(16), .LANES(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_signed (in_signed),
        .in_quad   (in_quad),
        .in_last   (in_last),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_tot++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    // One cycle, entered and left at a falling edge: drive the next queued beat,
    // score any result transferring at the coming rising edge.
    task automatic step();
        bit take, got;
        if (src_pos < src_n) begin
            in_valid  = 1'b1;
            in_data   = vt[src_list[src_pos]].data;
            in_signed = vt[src_list[src_pos]].sgn;
            in_quad   = vt[src_list[src_pos]].quad;
            in_last   = last_all || (src_pos == src_n - 1);
        end else begin
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
        #1;
        take = in_valid && in_ready;
        got  = out_valid && out_ready;
        if (in_valid && !in_ready && out_ready) stall_cnt++;
        if (got) begin
            if (out_pos < exp_n) chk("stream_data", out_data, vt[exp_list[out_pos]].exp);
            else chk("extra_output", DW'(out_pos), DW'(exp_n));
            out_pos++;
        end
        @(posedge clk);
        if (take) src_pos++;
        @(negedge clk);
    endtask

    task automatic load(input int n, input int s0, input int s1, input int s2,
                        input int s3, input int s4, input int s5);
        src_list = '{s0, s1, s2, s3, s4, s5, 0, 0};
        exp_list = src_list;
        src_n = n; exp_n = n; src_pos = 0; out_pos = 0; stall_cnt = 0;
    endtask

    initial begin
        int stale;
        n_pass = 0; n_tot = 0; last_all = 1'b1;
        rst = 1'b0; in_valid = 1'b0; in_data = '0; in_signed = 1'b0;
        in_quad = 1'b0; in_last = 1'b0; out_ready = 1'b1;

        vt[0] = '{{16'd8,16'd7,16'd6,16'd5,16'd4,16'd3,16'd2,16'd1}, 1'b1, 1'b0,
                  {32'd15, 32'd11, 32'd7, 32'd3}};
        vt[1] = '{{96'h0, 16'h0001, 16'hFFFF}, 1'b1, 1'b0, {96'h0, 32'h0000_0000}};
        vt[2] = '{{96'h0, 16'h0001, 16'hFFFF}, 1'b0, 1'b0, {96'h0, 32'h0001_0000}};
        vt[3] = '{{16'd8,16'd7,16'd6,16'd5,16'd4,16'd3,16'd2,16'd1}, 1'b0, 1'b1,
                  {32'd0, 32'd0, 32'd26, 32'd10}};
        vt[4] = '{{8{16'h8000}}, 1'b1, 1'b1, {64'h0, 32'hFFFE_0000, 32'hFFFE_0000}};
        vt[5] = '{{8{16'hFFFF}}, 1'b0, 1'b0, {4{32'h0001_FFFE}}};
        vt[6] = '{{96'h0, 16'h8000, 16'h7FFF}, 1'b1, 1'b0, {96'h0, 32'hFFFF_FFFF}};
        vt[7] = '{{8{16'h0001}}, 1'b0, 1'b0, {4{32'd6}}};

        repeat (2) @(negedge clk);
        chk("rst_out_valid", DW'(out_valid), DW'(0));
        chk("rst_out_data", out_data, DW'(0));
        chk("rst_in_ready", DW'(in_ready), DW'(1));
        rst = 1'b1;

        // Single beats: latency of two rising edges from presentation to out_valid.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = vt[i].data; in_signed = vt[i].sgn;
            in_quad = vt[i].quad; in_last = 1'b1;
            #1 chk("vec_in_ready", DW'(in_ready), DW'(1));
            @(negedge clk);
            in_valid = 1'b0;
            chk("vec_lat1_idle", DW'(out_valid), DW'(0));
            @(negedge clk);
            chk("vec_lat2_valid", DW'(out_valid), DW'(1));
            chk($sformatf("vec%0d_data", i), out_data, vt[i].exp);
        end
        @(negedge clk);

        // Back-to-back beats with mixed modes, full throughput.
        out_ready = 1'b1;
        load(6, 0, 1, 2, 3, 4, 5);
        repeat (10) step();
        chk("stream_count", DW'(out_pos), DW'(6));
        chk("stream_no_stall", DW'(stall_cnt), DW'(0));

        // Backpressure: three beats offered, only two fit.
        out_ready = 1'b0;
        load(3, 0, 3, 5, 0, 0, 0);
        repeat (4) step();
        chk("bp_accepted", DW'(src_pos), DW'(2));
        chk("bp_in_ready", DW'(in_ready), DW'(0));
        chk("bp_out_valid", DW'(out_valid), DW'(1));
        chk("bp_hold_data", out_data, vt[0].exp);
        repeat (2) step();
        chk("bp_hold_data2", out_data, vt[0].exp);
        out_ready = 1'b1;
        #1 chk("bp_release_ready", DW'(in_ready), DW'(1));
        repeat (8) step();
        chk("bp_out_count", DW'(out_pos), DW'(3));
        chk("bp_src_count", DW'(src_pos), DW'(3));
        chk("bp_drained", DW'(out_valid), DW'(0));

        // Reset with two beats in flight.
        out_ready = 1'b0;
        load(2, 0, 5, 0, 0, 0, 0);
        repeat (3) step();
        chk("pre_rst_valid", DW'(out_valid), DW'(1));
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("mid_rst_out_valid", DW'(out_valid), DW'(0));
        chk("mid_rst_out_data", out_data, DW'(0));
        chk("mid_rst_in_ready", DW'(in_ready), DW'(1));
        @(negedge clk);
        rst = 1'b1; out_ready = 1'b1;
        stale = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        chk("post_rst_stale", DW'(stale), DW'(0));

`ifdef ADJ_PAIR_ADD_ACC_EN
        // Three-beat group of all-ones lanes; only the last beat yields a result.
        last_all = 1'b0;
        load(3, 7, 7, 7, 0, 0, 0);
        exp_n = 1; exp_list[0] = 7;
        repeat (8) step();
        chk("acc_result_count", DW'(out_pos), DW'(1));
        last_all = 1'b1;
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/adj_pair_add_pipe.md
ADJ_PAIR_ADD_PIPE -- requirements
Module: adj_pair_add_pipe

Interface
REQ-001 The block SHALL have parameter LANE_W, default 16, meaning input lane width in bits (LANE_W >= 4).
REQ-002 The block SHALL have parameter LANES, default 8, meaning the number of input lanes; it SHALL be a multiple of 4.
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state is on the rising edge.
REQ-004 The block SHALL have port rst, input, 1, meaning reset, asynchronous, active-low.
REQ-005 The block SHALL have port in_data, input, LANES*LANE_W, meaning packed lanes; lane i = in_data[LANE_W*i +: LANE_W].
REQ-006 The block SHALL have port in_valid, input, 1, meaning the input beat is valid.
REQ-007 The block SHALL have port in_ready, output, 1, meaning the block accepts the beat.
REQ-008 The block SHALL have port in_signed, input, 1, meaning 1 = sign-extend lanes, 0 = zero-extend lanes; it is sampled with the beat.
REQ-009 The block SHALL have port in_quad, input, 1, meaning 0 = pair reduction, 1 = quad reduction; it is sampled with the beat.
REQ-010 The block SHALL have port in_last, input, 1, meaning the final beat of an accumulation group; it is used only under REQ-027.
REQ-011 The block SHALL have port out_data, output, LANES*LANE_W, meaning LANES/2 result slots; slot k = out_data[2*LANE_W*k +: 2*LANE_W].
REQ-012 The block SHALL have port out_valid, output, 1, meaning the result is valid.
REQ-013 The block SHALL have port out_ready, input, 1, meaning the downstream consumer accepts the result.

Function
REQ-014 A beat SHALL transfer on in_valid && in_ready; a result SHALL transfer on out_valid && out_ready.
REQ-015 Each lane SHALL be extended to 2*LANE_W bits: sign-extended when in_signed=1, zero-extended when in_signed=0.
REQ-016 Stage 1 SHALL register pair sums P[k] = ext(lane 2k+1) + ext(lane 2k) for k = 0..LANES/2-1, computed modulo 2^(2*LANE_W).
REQ-017 Stage 2, when in_quad=0, SHALL set slot k = P[k].
REQ-018 Stage 2, when in_quad=1, SHALL set slot j = P[2j] + P[2j+1] for j < LANES/4, and slots LANES/4 and above SHALL be zero.
REQ-019 The in_signed and in_quad values SHALL travel with their beat through the pipeline, so mode changes between beats take effect per beat.
REQ-020 Latency SHALL be 2 cycles: a beat accepted at edge N SHALL produce out_valid at edge N+2 when out_ready=1.
REQ-021 The pipeline SHALL be elastic: each stage holds one entry and advances when the next stage is empty or draining in the same cycle.
REQ-022 in_ready SHALL equal (stage 1 empty) OR (stage 1 advancing), and with out_ready held at 1 the block SHALL sustain one beat per cycle.
REQ-023 When out_valid=1 and out_ready=0, out_data SHALL be held stable and no beat SHALL be lost or duplicated.
REQ-024 When the pipeline is full and out_ready=0, in_ready SHALL be 0; on the cycle out_ready rises, in_ready SHALL be 1.
REQ-025 Accepting a new beat and emitting a result in the same cycle SHALL both take effect.

Reset
REQ-026 While rst=0, out_valid SHALL be 0, out_data SHALL be 0, all stage-valid flags SHALL be 0, in_ready SHALL be 1, and any in-flight beats SHALL be discarded; operation SHALL resume on the first edge after rst deasserts.

Configuration
REQ-027 When macro ADJ_PAIR_ADD_ACC_EN is defined, each slot SHALL accumulate its stage-2 results modulo 2^(2*LANE_W) across beats, out_valid SHALL assert only for a beat with in_last=1, carrying the group total, and the accumulators SHALL clear as that result transfers.
REQ-028 When ADJ_PAIR_ADD_ACC_EN is not defined, in_last SHALL be ignored, no accumulator SHALL exist, and every beat SHALL produce one result.
REQ-029 In accumulation mode, reset SHALL clear the accumulators, a non-last beat SHALL never assert out_valid, and in_quad SHALL be taken from the in_last beat.

Verification
REQ-030 The bench SHALL cover: defaults, lanes 0..7 = 1..8, signed=1, quad=0 -> out_data slots = 3, 7, 11, 15 two cycles later.
REQ-031 The bench SHALL cover: lane0=0xFFFF, lane1=0x0001, other lanes 0, signed=1 -> slot0 = 0x00000000; signed=0 -> slot0 = 0x00010000.
REQ-032 The bench SHALL cover: lanes 1..8, quad=1 -> slot0 = 10, slot1 = 26, slots 2 and 3 = 0.
REQ-033 The bench SHALL cover: out_ready=0 while 3 beats are offered -> 2 beats accepted and in_ready=0; after out_ready=1, the results SHALL emerge in order with none lost or duplicated.
REQ-034 The bench SHALL cover: rst pulsed low with 2 beats in flight -> out_valid=0 and out_data=0 immediately, and no stale result after release.
REQ-035 The bench SHALL cover, with ADJ_PAIR_ADD_ACC_EN: 3 beats of lanes all 1, the last with in_last=1 -> a single result with every slot = 6.
